// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter that serialises hold/clear/set/toggle commands from NREQ
// requesters onto a bank of NFLAG SR flops, keeping a shadow copy of the bank.

// One flag of the bank: registered S/R pulse plus its shadow bit.
module sr_bank_lane (
    input  logic       clk,
    input  logic       RST,
    input  logic       load,
    input  logic [1:0] op,
    input  logic       commit,
    output logic       s,
    output logic       r,
    output logic       q
);
    always_ff @(posedge clk) begin
        if (RST) begin
            s <= 1'b0;
            r <= 1'b0;
            q <= 1'b0;
        end else if (commit) begin
            q <= (q | s) & ~r;
            s <= 1'b0;
            r <= 1'b0;
        end else if (load) begin
            // Toggle resolves against the shadow bit, so S and R stay exclusive.
            s <= (op == 2'b10) || (op == 2'b11 && !q);
            r <= (op == 2'b01) || (op == 2'b11 && q);
        end
    end
endmodule

module sr_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IW    = $clog2(NFLAG),
    parameter int GW    = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               RST,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [2*NREQ-1:0]  req_op,
    input  logic [IW*NREQ-1:0] req_idx,
    output logic [NREQ-1:0]    req_ready,
    output logic [GW-1:0]      gnt_id,
    output logic [NFLAG-1:0]   s_vec,
    output logic [NFLAG-1:0]   r_vec,
    output logic [NFLAG-1:0]   q,
    output logic               busy,
    output logic               done
);
    typedef enum logic {IDLE, APPLY} state_t;

    typedef struct packed {
        logic [1:0]    op;
        logic [IW-1:0] idx;
    } cmd_t;

    state_t           state, nstate;
    logic [GW-1:0]    rr;
    logic [GW-1:0]    gsel;
    logic             found;
    logic             accept;
    cmd_t             cmd_sel;
    logic [NFLAG-1:0] lane_load;

    // Rotating priority search starting at rr.
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (int'(rr) + k) % NREQ;
            if (!found && req_valid[c]) begin
                found = 1'b1;
                gsel  = GW'(c);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && !RST && found)
            req_ready[gsel] = 1'b1;
    end

    assign accept      = |req_ready;
    assign cmd_sel.op  = req_op[2*gsel +: 2];
    assign cmd_sel.idx = req_idx[IW*gsel +: IW];

    always_ff @(posedge clk) begin
        if (RST) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (accept) nstate = APPLY;
            APPLY:   nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            rr     <= '0;
            gnt_id <= '0;
            done   <= 1'b0;
        end else begin
            done <= (state == APPLY);
            if (accept) begin
                gnt_id <= gsel;
                rr     <= (gsel == GW'(NREQ-1)) ? '0 : gsel + 1'b1;
            end
        end
    end

    assign busy = (state == APPLY);

    // An out-of-range index matches no lane, so it degrades to hold.
    generate
        for (genvar i = 0; i < NFLAG; i++) begin : g_lane
            assign lane_load[i] = accept && (cmd_sel.idx == IW'(i));
            sr_bank_lane u_lane (
                .clk    (clk),
                .RST    (RST),
                .load   (lane_load[i]),
                .op     (cmd_sel.op),
                .commit (busy),
                .s      (s_vec[i]),
                .r      (r_vec[i]),
                .q      (q[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Scoreboard bench for sr_bank_arbiter: directed commands push expected
// results; a negedge monitor checks each committed command and the invariants.
module tb_sr_bank_arbiter;
    localparam int NREQ = 4, NFLAG = 8, IW = 3, GW = 2;

    logic               clk = 1'b0;
    logic               RST;
    logic [NREQ-1:0]    req_valid;
    logic [2*NREQ-1:0]  req_op;
    logic [IW*NREQ-1:0] req_idx;
    logic [NREQ-1:0]    req_ready;
    logic [GW-1:0]      gnt_id;
    logic [NFLAG-1:0]   s_vec, r_vec, q;
    logic               busy, done;

    sr_bank_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG)) dut (
        .clk(clk), .RST(RST), .req_valid(req_valid), .req_op(req_op),
        .req_idx(req_idx), .req_ready(req_ready), .gnt_id(gnt_id),
        .s_vec(s_vec), .r_vec(r_vec), .q(q), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] op; logic [2:0] idx; } cmd_t;
    typedef struct { logic [1:0] g; logic [7:0] s; logic [7:0] r; logic [7:0] q; } exp_t;

    cmd_t cq[NREQ][$];
    exp_t sb[$];
    int   errors = 0, checks = 0;
    int   cyc = 0, last_done = -1;
    bit   gap_chk = 0;
    logic [7:0] cap_s, cap_r;
    logic [1:0] cap_g;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        chk("s_and_r", 32'(s_vec & r_vec), 0);
        if (!busy) chk("pulse_idle", {s_vec, r_vec}, 0);
        if (busy) begin
            cap_s = s_vec; cap_r = r_vec; cap_g = gnt_id;
        end
        if (done) begin
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                e = sb.pop_front();
                chk("gnt_id", 32'(cap_g), 32'(e.g));
                chk("s_pulse", 32'(cap_s), 32'(e.s));
                chk("r_pulse", 32'(cap_r), 32'(e.r));
                chk("q", 32'(q), 32'(e.q));
                chk("gnt_id_hold", 32'(gnt_id), 32'(e.g));
            end
            if (gap_chk && last_done >= 0) chk("done_gap", cyc - last_done, 2);
            last_done = cyc;
        end
    end

    task automatic push(input int r, input logic [1:0] op, input logic [2:0] idx,
                        input logic [1:0] g, input logic [7:0] s, input logic [7:0] rv,
                        input logic [7:0] qq);
        cmd_t c; exp_t e;
        c.op = op; c.idx = idx; cq[r].push_back(c);
        e.g = g; e.s = s; e.r = rv; e.q = qq; sb.push_back(e);
    endtask

    task automatic apply_fronts();
        for (int i = 0; i < NREQ; i++) begin
            if (cq[i].size() > 0) begin
                req_valid[i]      = 1'b1;
                req_op[2*i +: 2]  = cq[i][0].op;
                req_idx[3*i +: 3] = cq[i][0].idx;
            end else req_valid[i] = 1'b0;
        end
    endtask

    // Drive all queued commands, then wait for the scoreboard to drain.
    task automatic run(input string name);
        logic [NREQ-1:0] got;
        int budget = 200;
        apply_fronts();
        while (req_valid != 0 && budget > 0) begin
            @(negedge clk); got = req_valid & req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) if (got[i]) void'(cq[i].pop_front());
            apply_fronts();
            budget--;
        end
        while ((sb.size() != 0 || busy) && budget > 0) begin
            @(posedge clk); #1; budget--;
        end
        if (budget == 0) chk({name, "_timeout"}, 1, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        RST = 1'b1; req_valid = '1; req_op = '1; req_idx = '0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_ready", 32'(req_ready), 0);
            chk("rst_q", 32'(q), 0);
            chk("rst_sr", {s_vec, r_vec}, 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_gnt", 32'(gnt_id), 0);
        end
        req_valid = '0;
        @(posedge clk); #1; RST = 1'b0;
        @(posedge clk); #1;

        push(0, 2'b10, 3'd3, 2'd0, 8'h08, 8'h00, 8'h08);
        run("set3");
        push(0, 2'b01, 3'd3, 2'd0, 8'h00, 8'h08, 8'h00);
        run("clr3");

        push(2, 2'b11, 3'd5, 2'd2, 8'h20, 8'h00, 8'h20);
        push(2, 2'b11, 3'd5, 2'd2, 8'h00, 8'h20, 8'h00);
        run("toggle");

        // rr is now 3: req3 must win over req0.
        push(0, 2'b10, 3'd2, 2'd3, 8'h02, 8'h00, 8'h02);
        sb.delete();
        push(3, 2'b10, 3'd1, 2'd3, 8'h02, 8'h00, 8'h02);
        begin exp_t e; e.g = 2'd0; e.s = 8'h04; e.r = 8'h00; e.q = 8'h06; sb.push_back(e); end
        run("wrap");

        // Reset during APPLY of set idx 7.
        begin
            int budget = 20;
            req_valid = 4'b1000; req_op[7:6] = 2'b10; req_idx[11:9] = 3'd7;
            do begin @(negedge clk); budget--; end while (!req_ready[3] && budget > 0);
            if (budget == 0) chk("midrst_timeout", 1, 0);
            @(posedge clk); #1; req_valid = '0;
            @(negedge clk);
            chk("midrst_busy", 32'(busy), 1);
            chk("midrst_pulse", 32'(s_vec), 32'h80);
            RST = 1'b1;
            @(posedge clk); #1; RST = 1'b0;
            repeat (4) begin
                @(negedge clk);
                chk("midrst_done", 32'(done), 0);
                chk("midrst_s", 32'(s_vec), 0);
                chk("midrst_q", 32'(q), 0);
                chk("midrst_busy_after", 32'(busy), 0);
            end
            @(posedge clk); #1;
        end

        gap_chk = 1; last_done = -1;
        push(0, 2'b10, 3'd0, 2'd0, 8'h01, 8'h00, 8'h01);
        push(1, 2'b10, 3'd1, 2'd1, 8'h02, 8'h00, 8'h03);
        push(2, 2'b10, 3'd2, 2'd2, 8'h04, 8'h00, 8'h07);
        push(3, 2'b10, 3'd3, 2'd3, 8'h08, 8'h00, 8'h0F);
        push(0, 2'b00, 3'd0, 2'd0, 8'h00, 8'h00, 8'h0F);
        run("rr");
        gap_chk = 0;
        chk("rr_final_q", 32'(q), 32'h0F);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
